// File: rtl/axis_bram_recorder.sv
// axis_bram_recorder
//   Captures an AXI4-Stream into BRAM port B so a CPU can read the words back
//   later through BRAM port A. Software programs cfg_length, raises cfg_start
//   and polls sts_done / sts_count.
//   CONTINUOUS = 0 : one-shot, fills cfg_length words then stops in DONE.
//   CONTINUOUS = 1 : circular buffer of cfg_length words until cfg_start falls.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   cfg_start                level; rising edge arms a run, low aborts/re-arms
//   cfg_length               words per run, 0 selects the full BRAM depth
//   sts_count                one-shot: words written; continuous: next address
//   sts_busy / sts_done      high in RUN / DONE
//   s_axis_tdata/tvalid/tready  input stream
//   bram_portb_*             registered BRAM write port (clk, rst, addr, data, we)
module axis_bram_recorder #(
    parameter int DATA_WIDTH      = 32,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int CONTINUOUS      = 0
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_start,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_length,
    output logic [BRAM_ADDR_WIDTH:0]   sts_count,
    output logic                       sts_busy,
    output logic                       sts_done,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       bram_portb_clk,
    output logic                       bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
    output logic [DATA_WIDTH-1:0]      bram_portb_wrdata,
    output logic [DATA_WIDTH/8-1:0]    bram_portb_we
);

    localparam int AW   = BRAM_ADDR_WIDTH;
    localparam bit CIRC = (CONTINUOUS != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            start_q;
    logic [AW-1:0]   len_q;
    logic [AW:0]     ptr;
    logic            tready_q;
    logic            busy_q;
    logic            done_q;

    logic            rise;
    logic            beat;
    logic [AW-1:0]   last;
    logic            at_last;

    assign rise    = cfg_start & ~start_q;
    assign beat    = s_axis_tvalid & tready_q;
    // len_q = 0 wraps to all ones, i.e. the full depth
    assign last    = len_q - 1'b1;
    assign at_last = (ptr[AW-1:0] == last);

    assign sts_count      = ptr;
    assign sts_busy       = busy_q;
    assign sts_done       = done_q;
    assign s_axis_tready  = tready_q;
    assign bram_portb_clk = aclk;
    assign bram_portb_rst = ~aresetn;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= IDLE;
            start_q           <= 1'b0;
            len_q             <= '0;
            ptr               <= '0;
            tready_q          <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            bram_portb_addr   <= '0;
            bram_portb_wrdata <= '0;
            bram_portb_we     <= '0;
        end else begin
            start_q       <= cfg_start;
            bram_portb_we <= '0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        len_q    <= cfg_length;
                        ptr      <= '0;
                        state    <= RUN;
                        tready_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat) begin
                        bram_portb_addr   <= ptr[AW-1:0];
                        bram_portb_wrdata <= s_axis_tdata;
                        bram_portb_we     <= '1;
                        if (CIRC) begin
                            ptr <= at_last ? '0 : {1'b0, ptr[AW-1:0] + 1'b1};
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    // abort wins over completion; a beat in this cycle is still kept
                    if (!cfg_start) begin
                        state    <= IDLE;
                        tready_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (beat && at_last && !CIRC) begin
                        state    <= DONE;
                        tready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!cfg_start) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tready_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_bram_recorder.sv
// Testbench for axis_bram_recorder: one one-shot and one continuous instance
// (BRAM_ADDR_WIDTH = 4) share clock, reset, length and stream inputs, each has
// its own cfg_start. A reference model tracks expected status per cycle and
// pushes expected BRAM writes into a queue; a monitor pops them as the DUT
// asserts its write enable.
module tb_axis_bram_recorder;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          aresetn;
    logic [1:0]    start_v;
    logic [AW-1:0] cfg_length;
    logic [DW-1:0] tdata;
    logic          tvalid;

    logic [AW:0]     count_v  [2];
    logic [1:0]      busy_v;
    logic [1:0]      done_v;
    logic [1:0]      tready_v;
    logic [1:0]      bclk_v;
    logic [1:0]      brst_v;
    logic [AW-1:0]   addr_v   [2];
    logic [DW-1:0]   wrdata_v [2];
    logic [DW/8-1:0] we_v     [2];

    int checks = 0;
    int errors = 0;

    // reference model state (state after the next clock edge once updated)
    bit          m_run  [2];
    bit          m_done [2];
    int          m_ptr  [2];
    int          m_len  [2];
    logic [DW-1:0] mem_m  [2][DEPTH];
    logic [DW-1:0] bram_tb[2][DEPTH];
    logic [AW+DW-1:0] q0[$];
    logic [AW+DW-1:0] q1[$];

    axis_bram_recorder #(
        .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CONTINUOUS(0)
    ) u_os (
        .aclk(clk), .aresetn(aresetn), .cfg_start(start_v[0]), .cfg_length(cfg_length),
        .sts_count(count_v[0]), .sts_busy(busy_v[0]), .sts_done(done_v[0]),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_v[0]),
        .bram_portb_clk(bclk_v[0]), .bram_portb_rst(brst_v[0]), .bram_portb_addr(addr_v[0]),
        .bram_portb_wrdata(wrdata_v[0]), .bram_portb_we(we_v[0])
    );

    axis_bram_recorder #(
        .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CONTINUOUS(1)
    ) u_ct (
        .aclk(clk), .aresetn(aresetn), .cfg_start(start_v[1]), .cfg_length(cfg_length),
        .sts_count(count_v[1]), .sts_busy(busy_v[1]), .sts_done(done_v[1]),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_v[1]),
        .bram_portb_clk(bclk_v[1]), .bram_portb_rst(brst_v[1]), .bram_portb_addr(addr_v[1]),
        .bram_portb_wrdata(wrdata_v[1]), .bram_portb_we(we_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // monitor: every DUT write must match the oldest expected write
    always @(negedge clk) begin
        if (aresetn) begin
            for (int m = 0; m < 2; m++) begin
                if (we_v[m] !== '0) begin
                    logic [AW+DW-1:0] e;
                    chk(m == 0 ? "os_we_all_ones" : "ct_we_all_ones", we_v[m], 4'hF);
                    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                        chk(m == 0 ? "os_unexpected_write" : "ct_unexpected_write", 1, 0);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        chk(m == 0 ? "os_wr_addr" : "ct_wr_addr", addr_v[m], e[AW+DW-1:DW]);
                        chk(m == 0 ? "os_wr_data" : "ct_wr_data", wrdata_v[m], e[DW-1:0]);
                    end
                    bram_tb[m][addr_v[m]] = wrdata_v[m];
                end
            end
        end
    end

    // called at a negedge; cfg_start rises, RUN is visible at the next negedge
    task automatic arm(input int m, input int len);
        cfg_length = len[AW-1:0];
        start_v[m] = 1'b1;
        m_len[m]  = (len == 0) ? DEPTH : len;
        m_ptr[m]  = 0;
        m_run[m]  = 1'b1;
        m_done[m] = 1'b0;
        @(negedge clk);
    endtask

    // one cycle: check status, offer a word with probability pv%, optionally drop cfg_start
    task automatic step(input int m, input int pv, input bit drop);
        logic [DW-1:0] d;
        int a;
        chk(m == 0 ? "os_tready" : "ct_tready", tready_v[m], m_run[m]);
        chk(m == 0 ? "os_busy" : "ct_busy", busy_v[m], m_run[m]);
        chk(m == 0 ? "os_done" : "ct_done", done_v[m], m_done[m]);
        chk(m == 0 ? "os_count" : "ct_count", count_v[m], m_ptr[m]);
        d = $urandom;
        tdata = d;
        tvalid = ($urandom_range(99) < pv);
        if (drop) start_v[m] = 1'b0;
        if (tvalid && m_run[m]) begin
            a = m_ptr[m] % DEPTH;
            if (m == 0) q0.push_back({a[AW-1:0], d});
            else        q1.push_back({a[AW-1:0], d});
            mem_m[m][a] = d;
            if (m == 1) begin
                m_ptr[m] = (m_ptr[m] + 1) % m_len[m];
            end else begin
                m_ptr[m]++;
                if (m_ptr[m] == m_len[m]) begin
                    m_run[m]  = 1'b0;
                    m_done[m] = 1'b1;
                end
            end
        end
        if (drop) begin
            m_run[m]  = 1'b0;
            m_done[m] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        for (int m = 0; m < 2; m++) begin
            chk("rst_tready", tready_v[m], 0);
            chk("rst_busy", busy_v[m], 0);
            chk("rst_done", done_v[m], 0);
            chk("rst_count", count_v[m], 0);
            chk("rst_we", we_v[m], 0);
            chk("rst_addr", addr_v[m], 0);
            chk("rst_wrdata", wrdata_v[m], 0);
            chk("rst_bram_rst", brst_v[m], 1);
        end
    endtask

    // asynchronous assertion between clock edges, release at a negedge
    task automatic do_reset();
        tvalid = 1'b0;
        #2;
        chk("q_empty_before_reset", q0.size() + q1.size(), 0);
        aresetn = 1'b0;
        start_v = '0;
        #1;
        check_reset_outputs();
        for (int m = 0; m < 2; m++) begin
            m_run[m] = 1'b0; m_done[m] = 1'b0; m_ptr[m] = 0;
        end
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; start_v = '0; cfg_length = '0; tdata = '0; tvalid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_run[m] = 1'b0; m_done[m] = 1'b0; m_ptr[m] = 0; m_len[m] = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[m][i] = '0; bram_tb[m][i] = '0;
            end
        end
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (2) step(0, 100, 0);

        // one-shot, 4 words back to back, then stall with start held high
        arm(0, 4);
        repeat (8) step(0, 100, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        // full depth
        arm(0, 0);
        repeat (22) step(0, 100, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        // gapped valid
        arm(0, 3);
        repeat (16) step(0, 50, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        // abort after 3 beats, then re-arm overwrites address 0
        arm(0, 8);
        repeat (3) step(0, 100, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        arm(0, 8);
        repeat (2) step(0, 100, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        // random one-shot runs, abort cycle may carry a beat
        for (int r = 0; r < 6; r++) begin
            arm(0, $urandom_range(DEPTH - 1));
            repeat ($urandom_range(30)) step(0, 70, 0);
            step(0, 60, 1);
            step(0, 0, 0);
        end

        // continuous, length 6, 14 beats
        arm(1, 6);
        repeat (14) step(1, 100, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            arm(1, $urandom_range(DEPTH - 1));
            repeat ($urandom_range(40)) step(1, 70, 0);
            step(1, 60, 1);
            step(1, 0, 0);
        end

        // reset mid-run, then stay idle until a new rise
        arm(0, 10);
        repeat (4) step(0, 100, 0);
        do_reset();
        repeat (3) step(0, 100, 0);
        arm(0, 2);
        repeat (4) step(0, 100, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        chk("q_empty_end", q0.size() + q1.size(), 0);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < DEPTH; i++)
                chk(m == 0 ? "os_bram" : "ct_bram", bram_tb[m][i], mem_m[m][i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
